// File: rtl/mix_columns_if.sv
// -----------------------------------------------------------------------------
// mix_columns_if
//   Block-level handshake bundle for the (Inv)MixColumns engine.
//   The input side carries a full state with a mode bit. The output side returns
//   the transformed state. Both sides use valid/ready.
//
//   State layout (in_state / out_state, declared [0:32*NB-1]):
//     column c, byte r occupies bits 32c+8r .. 32c+8r+7, MSB at the lower index.
//
//   Signals
//     in_valid   producer -> engine  block present
//     in_ready   engine -> producer  engine can accept a block
//     in_inv     producer -> engine  1 = InvMixColumns, 0 = MixColumns
//     in_state   producer -> engine  input state
//     out_valid  engine -> consumer  result present
//     out_ready  consumer -> engine  consumer accepts result
//     out_state  engine -> consumer  result state
//
//   Modports: master = producer/consumer side, slave = engine side.
// -----------------------------------------------------------------------------
interface mix_columns_if #(
  parameter int NB = 4
);
  logic             in_valid;
  logic             in_ready;
  logic             in_inv;
  logic [0:32*NB-1] in_state;
  logic             out_valid;
  logic             out_ready;
  logic [0:32*NB-1] out_state;

  modport master (
    output in_valid, in_inv, in_state, out_ready,
    input  in_ready, out_valid, out_state
  );

  modport slave (
    input  in_valid, in_inv, in_state, out_ready,
    output in_ready, out_valid, out_state
  );
endinterface

// File: rtl/mix_columns_engine.sv
// -----------------------------------------------------------------------------
// mix_columns_engine
//   Iterative (Inv)MixColumns engine for the AES/Rijndael round datapath.
//   A full state (NB columns) is loaded on the input handshake. It is then
//   transformed in place, COLS_PER_CYCLE columns per clock, and presented on
//   the output handshake.
//
//   Parameters
//     NB              number of 32-bit state columns (4, 6 or 8)
//     COLS_PER_CYCLE  columns transformed per clock (must divide NB)
//
//   Ports
//     clk     rising-edge clock
//     rst_n   asynchronous active-low reset; aborts any block in flight
//     mc      mix_columns_if.slave handshake bundle (see mix_columns_if.sv)
//     busy    high while the engine is transforming a block
//
//   Build option
//     MIXCOL_FWD_EN  when defined, the forward MixColumns datapath and the
//                    per-block mode register are compiled in, and in_inv
//                    selects the mode. When undefined, the engine is
//                    inverse-only and in_inv is ignored.
//
//   Latency: handshake at edge k -> out_valid after edge k + NB/COLS_PER_CYCLE.
// -----------------------------------------------------------------------------
module mix_columns_engine #(
  parameter int NB             = 4,
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  mix_columns_if.slave mc,
  output logic         busy
);

  localparam int GROUPS = NB / COLS_PER_CYCLE;
  localparam int IDX_W  = 4;
  localparam logic [IDX_W-1:0] STEP      = IDX_W'(COLS_PER_CYCLE);
  localparam logic [IDX_W-1:0] LAST_BASE = IDX_W'(NB - COLS_PER_CYCLE);

  generate
    if (NB != 4 && NB != 6 && NB != 8) begin : g_bad_nb
      $error("mix_columns_engine: NB must be 4, 6 or 8");
    end
    if (COLS_PER_CYCLE < 1 || COLS_PER_CYCLE > NB || (NB % COLS_PER_CYCLE) != 0) begin : g_bad_cpc
      $error("mix_columns_engine: COLS_PER_CYCLE must divide NB");
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // GF(2^8) helpers, reduction polynomial x^8+x^4+x^3+x+1
  // ---------------------------------------------------------------------------
  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul09(input logic [7:0] x);
    return xtime(xtime(xtime(x))) ^ x;
  endfunction

  function automatic logic [7:0] gf_mul0b(input logic [7:0] x);
    return xtime(xtime(xtime(x))) ^ xtime(x) ^ x;
  endfunction

  function automatic logic [7:0] gf_mul0d(input logic [7:0] x);
    return xtime(xtime(xtime(x))) ^ xtime(xtime(x)) ^ x;
  endfunction

  function automatic logic [7:0] gf_mul0e(input logic [7:0] x);
    return xtime(xtime(xtime(x))) ^ xtime(xtime(x)) ^ xtime(x);
  endfunction

  // A column is packed with byte 0 in [31:24], matching the state layout
  // where the lowest state index of a column is byte 0's MSB.
  function automatic logic [31:0] inv_mix(input logic [31:0] col);
    logic [7:0] b0, b1, b2, b3;
    logic [7:0] r0, r1, r2, r3;
    b0 = col[31:24];
    b1 = col[23:16];
    b2 = col[15:8];
    b3 = col[7:0];
    r0 = gf_mul0e(b0) ^ gf_mul0b(b1) ^ gf_mul0d(b2) ^ gf_mul09(b3);
    r1 = gf_mul0e(b1) ^ gf_mul0b(b2) ^ gf_mul0d(b3) ^ gf_mul09(b0);
    r2 = gf_mul0e(b2) ^ gf_mul0b(b3) ^ gf_mul0d(b0) ^ gf_mul09(b1);
    r3 = gf_mul0e(b3) ^ gf_mul0b(b0) ^ gf_mul0d(b1) ^ gf_mul09(b2);
    return {r0, r1, r2, r3};
  endfunction

`ifdef MIXCOL_FWD_EN
  function automatic logic [7:0] gf_mul03(input logic [7:0] x);
    return xtime(x) ^ x;
  endfunction

  function automatic logic [31:0] fwd_mix(input logic [31:0] col);
    logic [7:0] b0, b1, b2, b3;
    logic [7:0] r0, r1, r2, r3;
    b0 = col[31:24];
    b1 = col[23:16];
    b2 = col[15:8];
    b3 = col[7:0];
    r0 = xtime(b0) ^ gf_mul03(b1) ^ b2 ^ b3;
    r1 = xtime(b1) ^ gf_mul03(b2) ^ b3 ^ b0;
    r2 = xtime(b2) ^ gf_mul03(b3) ^ b0 ^ b1;
    r3 = xtime(b3) ^ gf_mul03(b0) ^ b1 ^ b2;
    return {r0, r1, r2, r3};
  endfunction
`endif

  // ---------------------------------------------------------------------------
  // Control: FSM, column counter, handshake
  // ---------------------------------------------------------------------------
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] col_idx_q;
  logic             load;
  logic             last_grp;

  assign mc.in_ready = (state_q == IDLE) || (state_q == DONE && mc.out_ready);
  assign load        = mc.in_valid && mc.in_ready;
  assign last_grp    = (col_idx_q == LAST_BASE);
  assign busy        = (state_q == BUSY);
  assign mc.out_valid = (state_q == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (load) state_d = BUSY;
      BUSY: if (last_grp) state_d = DONE;
      DONE: begin
        if (mc.out_ready) state_d = mc.in_valid ? BUSY : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_idx_q <= '0;
    end else if (load) begin
      col_idx_q <= '0;
    end else if (state_q == BUSY) begin
      col_idx_q <= col_idx_q + STEP;
    end
  end

`ifdef MIXCOL_FWD_EN
  // Mode is captured once per block so in_inv toggling mid-block is harmless.
  logic mode_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q <= 1'b0;
    end else if (load) begin
      mode_q <= mc.in_inv;
    end
  end
`else
  logic unused_in_inv;
  assign unused_in_inv = mc.in_inv;
`endif

  // ---------------------------------------------------------------------------
  // Datapath: select the active column group, transform, write back in place
  // ---------------------------------------------------------------------------
  logic [31:0] work_q  [NB];
  logic [31:0] grp_out [COLS_PER_CYCLE];

  for (genvar g = 0; g < COLS_PER_CYCLE; g++) begin : g_grp
    // One-hot AND-OR mux over the column groups, since col_idx only ever
    // holds a multiple of COLS_PER_CYCLE.
    logic [31:0] acc [GROUPS+1];
    assign acc[0] = '0;
    for (genvar k = 0; k < GROUPS; k++) begin : g_sel
      localparam logic [IDX_W-1:0] BASE = IDX_W'(k * COLS_PER_CYCLE);
      assign acc[k+1] = acc[k] | ({32{col_idx_q == BASE}} & work_q[k*COLS_PER_CYCLE + g]);
    end

`ifdef MIXCOL_FWD_EN
    assign grp_out[g] = mode_q ? inv_mix(acc[GROUPS]) : fwd_mix(acc[GROUPS]);
`else
    assign grp_out[g] = inv_mix(acc[GROUPS]);
`endif
  end

  for (genvar c = 0; c < NB; c++) begin : g_col
    localparam int GI = c % COLS_PER_CYCLE;
    localparam logic [IDX_W-1:0] CBASE = IDX_W'((c / COLS_PER_CYCLE) * COLS_PER_CYCLE);

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        work_q[c] <= '0;
      end else if (load) begin
        work_q[c] <= mc.in_state[32*c +: 32];
      end else if (state_q == BUSY && col_idx_q == CBASE) begin
        work_q[c] <= grp_out[GI];
      end
    end

    // Gated so a partially transformed state is never visible downstream.
    assign mc.out_state[32*c +: 32] = (state_q == DONE) ? work_q[c] : 32'h0;
  end

endmodule

// File: tb/tb_mix_columns_engine.sv
// -----------------------------------------------------------------------------
// tb_mix_columns_engine
//   Directed bench for mix_columns_engine. Two instances are exercised:
//     u_dut4 : NB=4, COLS_PER_CYCLE=1
//     u_dut8 : NB=8, COLS_PER_CYCLE=2
//   Expected states are the FIPS-197 / reference MixColumns column pairs.
//   When MIXCOL_FWD_EN is not defined, the forward cases are replaced by
//   inverse cases driven with in_inv=0, which the engine must ignore.
// -----------------------------------------------------------------------------
module tb_mix_columns_engine;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic busy4, busy8;

  int n_cmp = 0;
  int n_mis = 0;

  always #5 clk = ~clk;

  mix_columns_if #(.NB(4)) if4 ();
  mix_columns_if #(.NB(8)) if8 ();

  mix_columns_engine #(.NB(4), .COLS_PER_CYCLE(1)) u_dut4 (
    .clk  (clk),
    .rst_n(rst_n),
    .mc   (if4),
    .busy (busy4)
  );

  mix_columns_engine #(.NB(8), .COLS_PER_CYCLE(2)) u_dut8 (
    .clk  (clk),
    .rst_n(rst_n),
    .mc   (if8),
    .busy (busy8)
  );

  localparam logic [127:0] FA = {32'hdb135345, 32'hf20a225c, 32'h01010101, 32'hc6c6c6c6};
  localparam logic [127:0] FB = {32'h8e4da1bc, 32'h9fdc589d, 32'h01010101, 32'hc6c6c6c6};
  localparam logic [127:0] IA = {32'h8e4da1bc, 32'h9fdc589d, 32'hd5d5d7d6, 32'h4d7ebdf8};
  localparam logic [127:0] IB = {32'hdb135345, 32'hf20a225c, 32'hd4d4d4d5, 32'h2d26314c};
  localparam logic [255:0] D8 = {8{32'hd4d4d4d5}};
  localparam logic [255:0] M8 = {8{32'hd5d5d7d6}};

`ifdef MIXCOL_FWD_EN
  localparam logic [127:0] T1_IN  = FA;
  localparam logic [127:0] T1_OUT = FB;
  localparam logic [255:0] T8_IN  = D8;
  localparam logic [255:0] T8_OUT = M8;
`else
  localparam logic [127:0] T1_IN  = FB;
  localparam logic [127:0] T1_OUT = FA;
  localparam logic [255:0] T8_IN  = M8;
  localparam logic [255:0] T8_OUT = D8;
`endif

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Counts edges from the handshake edge until out_valid, bounded.
  task automatic wait_out4(output int lat);
    lat = 0;
    while (!if4.out_valid && lat < 20) begin
      tick();
      lat++;
    end
  endtask

  task automatic blk4(input string tag, input logic [127:0] st, input logic inv,
                      input logic [127:0] exp);
    int lat;
    chk({tag, "_in_ready"}, if4.in_ready, 1'b1);
    if4.in_state = st;
    if4.in_inv   = inv;
    if4.in_valid = 1'b1;
    tick();
    // Scramble inputs while busy; the block in flight must not notice.
    if4.in_valid = 1'b0;
    if4.in_state = ~st;
    if4.in_inv   = ~inv;
    chk({tag, "_busy"}, busy4, 1'b1);
    wait_out4(lat);
    chk({tag, "_latency"}, lat, 4);
    chk({tag, "_out_state"}, if4.out_state, exp);
  endtask

  task automatic drain4(input string tag);
    if4.out_ready = 1'b1;
    tick();
    if4.out_ready = 1'b0;
    chk({tag, "_drained"}, if4.out_valid, 1'b0);
  endtask

  task automatic blk8(input string tag, input logic [255:0] st, input logic inv,
                      input logic [255:0] exp);
    int lat;
    chk({tag, "_in_ready"}, if8.in_ready, 1'b1);
    if8.in_state = st;
    if8.in_inv   = inv;
    if8.in_valid = 1'b1;
    tick();
    if8.in_valid = 1'b0;
    if8.in_state = ~st;
    if8.in_inv   = ~inv;
    chk({tag, "_busy"}, busy8, 1'b1);
    lat = 0;
    while (!if8.out_valid && lat < 20) begin
      tick();
      lat++;
    end
    chk({tag, "_latency"}, lat, 4);
    chk({tag, "_out_state"}, if8.out_state, exp);
    if8.out_ready = 1'b1;
    tick();
    if8.out_ready = 1'b0;
    chk({tag, "_drained"}, if8.out_valid, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int lat;
    if4.in_valid = 1'b0; if4.in_inv = 1'b0; if4.in_state = '0; if4.out_ready = 1'b0;
    if8.in_valid = 1'b0; if8.in_inv = 1'b0; if8.in_state = '0; if8.out_ready = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    chk("rst_in_ready", if4.in_ready, 1'b1);
    chk("rst_out_valid", if4.out_valid, 1'b0);
    chk("rst_busy", busy4, 1'b0);
    chk("rst_out_state", if4.out_state, '0);
    chk("rst_out_valid8", if8.out_valid, 1'b0);
    tick();

    // Forward columns (or inverse-only substitute), then inverse columns
    blk4("t1_fwd", T1_IN, 1'b0, T1_OUT);
    drain4("t1_fwd");
    blk4("t2_inv", IA, 1'b1, IB);
    drain4("t2_inv");

    // NB=8, two columns per cycle, mixed mode
    blk8("t3_nb8_a", T8_IN, 1'b0, T8_OUT);
    blk8("t3_nb8_b", M8, 1'b1, D8);
    chk("t3_busy8_idle", busy8, 1'b0);

    // Backpressure in DONE, then same-edge transfer and accept
    blk4("t4_bp", IA, 1'b1, IB);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("t4_hold_state", if4.out_state, IB);
      chk("t4_hold_valid", if4.out_valid, 1'b1);
      chk("t4_hold_in_ready", if4.in_ready, 1'b0);
    end
    if4.in_state  = T1_IN;
    if4.in_inv    = 1'b0;
    if4.in_valid  = 1'b1;
    if4.out_ready = 1'b1;
    #1;
    chk("t4_accept_ready", if4.in_ready, 1'b1);
    tick();
    if4.in_valid  = 1'b0;
    if4.out_ready = 1'b0;
    if4.in_state  = '0;
    chk("t4_next_busy", busy4, 1'b1);
    chk("t4_next_valid", if4.out_valid, 1'b0);
    wait_out4(lat);
    chk("t4_next_latency", lat, 4);
    chk("t4_next_state", if4.out_state, T1_OUT);
    drain4("t4_next");

    // Reset two cycles into a block
    if4.in_state = IA;
    if4.in_inv   = 1'b1;
    if4.in_valid = 1'b1;
    tick();
    if4.in_valid = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    chk("t5_rst_valid", if4.out_valid, 1'b0);
    chk("t5_rst_busy", busy4, 1'b0);
    chk("t5_rst_state", if4.out_state, '0);
    tick();
    rst_n = 1'b1;
    #1;
    chk("t5_post_rst_ready", if4.in_ready, 1'b1);
    tick();
    blk4("t5_fresh", T1_IN, 1'b0, T1_OUT);
    drain4("t5_fresh");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
